wb_commit_stage: RTL

Parametrised writeback/commit stage for the five-stage in-order core. Accepts one instruction at a time from MEM, retires it to the register file, and owns a basic privileged CSR set: CRMD, PRMD, ESTAT, ERA, EENTRY and NUM_SAVE SAVE registers. It commits exceptions and `ertn`, and emits a one-cycle pipeline flush with a redirect target for the fetch stage.

---
 rtl/wb_pkg.sv | 47 ++++
 rtl/wb_csr_file.sv | 100 ++++++++++
 rtl/wb_commit_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback/commit stage: CSR addresses, field
// positions, reset values and csr_op bit indices.
// Imported by wb_csr_file and wb_commit_stage.
package wb_pkg;

    // CSR addresses
    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_EENTRY    = 14'h00C;
    localparam logic [13:0] CSR_SAVE_BASE = 14'h030;

    // CRMD fields
    localparam int CRMD_PLV_LSB = 0;
    localparam int CRMD_PLV_W   = 2;
    localparam int CRMD_IE_BIT  = 2;

    // PRMD fields
    localparam int PRMD_PPLV_LSB = 0;
    localparam int PRMD_PIE_BIT  = 2;

    // ESTAT fields
    localparam int ESTAT_ECODE_LSB = 16;
    localparam int ESTAT_ECODE_W   = 6;
    localparam int ESTAT_ESUB_LSB  = 22;
    localparam int ESTAT_ESUB_W    = 9;

    // EENTRY: entry point is 64-byte aligned
    localparam int EENTRY_VA_LSB = 6;

    // Software-writable bits in the low 32 bits
    localparam logic [31:0] CRMD_WBITS  = 32'h0000_000F;
    localparam logic [31:0] PRMD_WBITS  = 32'h0000_0007;
    localparam logic [31:0] ESTAT_WBITS = 32'h0000_0003;

    // Reset values
    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;   // DA = 1
    localparam logic [31:0] CSR_ZERO   = 32'h0000_0000;

    // csr_op bit indices, csr_op = {csrrd, csrwr, csrxchg, ertn}
    localparam int OP_ERTN    = 0;
    localparam int OP_CSRXCHG = 1;
    localparam int OP_CSRWR   = 2;
    localparam int OP_CSRRD   = 3;

endpackage

// File: rtl/wb_csr_file.sv
// Privileged CSR storage: CRMD, PRMD, ESTAT, ERA, EENTRY and NUM_SAVE SAVEn.
// Ports: combinational read by csr_num; masked write, exception and ertn
// updates land at the next clk edge; era/eentry exported for redirects.
module wb_csr_file
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_SAVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [13:0]       csr_num,
    output logic [DATA_W-1:0] csr_rdata,
    input  logic              csr_we,
    input  logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_wmask,
    input  logic              ex_commit,
    input  logic [5:0]        ex_ecode,
    input  logic [8:0]        ex_esubcode,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              ertn_commit,
    output logic [DATA_W-1:0] era,
    output logic [DATA_W-1:0] eentry
);

    localparam logic [DATA_W-1:0] CRMD_WM   = DATA_W'(CRMD_WBITS);
    localparam logic [DATA_W-1:0] PRMD_WM   = DATA_W'(PRMD_WBITS);
    localparam logic [DATA_W-1:0] ESTAT_WM  = DATA_W'(ESTAT_WBITS);
    localparam logic [DATA_W-1:0] EENTRY_WM =
        {{(DATA_W-EENTRY_VA_LSB){1'b1}}, {EENTRY_VA_LSB{1'b0}}};

    logic [DATA_W-1:0] crmd_r;
    logic [DATA_W-1:0] prmd_r;
    logic [DATA_W-1:0] estat_r;
    logic [DATA_W-1:0] era_r;
    logic [DATA_W-1:0] eentry_r;
    logic [DATA_W-1:0] save_r [NUM_SAVE];

    // Only bits that are both selected by the instruction mask and
    // software-writable in the target register change.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] wbits);
        logic [DATA_W-1:0] m;
        m = csr_wmask & wbits;
        return (old & ~m) | (csr_wdata & m);
    endfunction

    always_comb begin
        csr_rdata = '0;
        case (csr_num)
            CSR_CRMD:   csr_rdata = crmd_r;
            CSR_PRMD:   csr_rdata = prmd_r;
            CSR_ESTAT:  csr_rdata = estat_r;
            CSR_ERA:    csr_rdata = era_r;
            CSR_EENTRY: csr_rdata = eentry_r;
            default:    ;
        endcase
        for (int i = 0; i < NUM_SAVE; i++) begin
            if (csr_num == CSR_SAVE_BASE + 14'(i)) csr_rdata = save_r[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_r   <= DATA_W'(CRMD_RESET);
            prmd_r   <= DATA_W'(CSR_ZERO);
            estat_r  <= DATA_W'(CSR_ZERO);
            era_r    <= DATA_W'(CSR_ZERO);
            eentry_r <= DATA_W'(CSR_ZERO);
            for (int i = 0; i < NUM_SAVE; i++) save_r[i] <= '0;
        end else if (ex_commit) begin
            prmd_r[PRMD_PPLV_LSB +: CRMD_PLV_W]       <= crmd_r[CRMD_PLV_LSB +: CRMD_PLV_W];
            prmd_r[PRMD_PIE_BIT]                      <= crmd_r[CRMD_IE_BIT];
            crmd_r[CRMD_PLV_LSB +: CRMD_PLV_W]        <= '0;
            crmd_r[CRMD_IE_BIT]                       <= 1'b0;
            estat_r[ESTAT_ECODE_LSB +: ESTAT_ECODE_W] <= ex_ecode;
            estat_r[ESTAT_ESUB_LSB +: ESTAT_ESUB_W]   <= ex_esubcode;
            era_r                                     <= ex_pc;
        end else if (ertn_commit) begin
            crmd_r[CRMD_PLV_LSB +: CRMD_PLV_W] <= prmd_r[PRMD_PPLV_LSB +: CRMD_PLV_W];
            crmd_r[CRMD_IE_BIT]                <= prmd_r[PRMD_PIE_BIT];
        end else if (csr_we) begin
            case (csr_num)
                CSR_CRMD:   crmd_r   <= merge(crmd_r,   CRMD_WM);
                CSR_PRMD:   prmd_r   <= merge(prmd_r,   PRMD_WM);
                CSR_ESTAT:  estat_r  <= merge(estat_r,  ESTAT_WM);
                CSR_ERA:    era_r    <= merge(era_r,    '1);
                CSR_EENTRY: eentry_r <= merge(eentry_r, EENTRY_WM);
                default:    ;
            endcase
            for (int i = 0; i < NUM_SAVE; i++) begin
                if (csr_num == CSR_SAVE_BASE + 14'(i)) save_r[i] <= merge(save_r[i], '1);
            end
        end
    end

    assign era    = era_r;
    assign eentry = eentry_r;

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: one-entry pipe register from MEM, GPR retire,
// CSR access, exception/ertn commit with a one-cycle flush + redirect.
// Ports: ms_* handshake in, rf_* write port, flush/flush_target, debug trace.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RF_AW    = 5,
    parameter int NUM_SAVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [DATA_W-1:0] ms_pc,
    input  logic              ms_gr_we,
    input  logic [RF_AW-1:0]  ms_dest,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [3:0]        ms_csr_op,
    input  logic [13:0]       ms_csr_num,
    input  logic [DATA_W-1:0] ms_csr_wdata,
    input  logic [DATA_W-1:0] ms_csr_wmask,
    input  logic              ms_ex,
    input  logic [5:0]        ms_ecode,
    input  logic [8:0]        ms_esubcode,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flush,
    output logic [DATA_W-1:0] flush_target,
    output logic [DATA_W-1:0] debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [RF_AW-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);

    logic              ws_valid;
    logic              ws_ready_go;
    logic [DATA_W-1:0] ws_pc;
    logic              ws_gr_we;
    logic [RF_AW-1:0]  ws_dest;
    logic [DATA_W-1:0] ws_result;
    logic [3:0]        ws_csr_op;
    logic [13:0]       ws_csr_num;
    logic [DATA_W-1:0] ws_csr_wdata;
    logic [DATA_W-1:0] ws_csr_wmask;
    logic              ws_ex;
    logic [5:0]        ws_ecode;
    logic [8:0]        ws_esubcode;

    logic              do_ex;
    logic              do_ertn;
    logic              do_csr;
    logic              csr_we;
    logic [DATA_W-1:0] csr_mask;
    logic [DATA_W-1:0] csr_rdata;
    logic [DATA_W-1:0] era;
    logic [DATA_W-1:0] eentry;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // A flushing commit kills whatever MEM offers in the same cycle, since
    // upstream is being flushed too.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_to_ws_valid && ws_allowin) begin
            ws_pc        <= ms_pc;
            ws_gr_we     <= ms_gr_we;
            ws_dest      <= ms_dest;
            ws_result    <= ms_result;
            ws_csr_op    <= ms_csr_op;
            ws_csr_num   <= ms_csr_num;
            ws_csr_wdata <= ms_csr_wdata;
            ws_csr_wmask <= ms_csr_wmask;
            ws_ex        <= ms_ex;
            ws_ecode     <= ms_ecode;
            ws_esubcode  <= ms_esubcode;
        end
    end

    // Priority: exception > ertn > CSR access > plain writeback.
    assign do_ex    = ws_valid && ws_ex;
    assign do_ertn  = ws_valid && !ws_ex && ws_csr_op[OP_ERTN];
    assign do_csr   = ws_valid && !ws_ex && !ws_csr_op[OP_ERTN] &&
                      (ws_csr_op[OP_CSRRD] || ws_csr_op[OP_CSRWR] || ws_csr_op[OP_CSRXCHG]);
    assign csr_we   = do_csr && (ws_csr_op[OP_CSRWR] || ws_csr_op[OP_CSRXCHG]);
    assign csr_mask = ws_csr_op[OP_CSRXCHG] ? ws_csr_wmask : '1;

    wb_csr_file #(
        .DATA_W   (DATA_W),
        .NUM_SAVE (NUM_SAVE)
    ) u_csr (
        .clk         (clk),
        .reset       (reset),
        .csr_num     (ws_csr_num),
        .csr_rdata   (csr_rdata),
        .csr_we      (csr_we),
        .csr_wdata   (ws_csr_wdata),
        .csr_wmask   (csr_mask),
        .ex_commit   (do_ex),
        .ex_ecode    (ws_ecode),
        .ex_esubcode (ws_esubcode),
        .ex_pc       (ws_pc),
        .ertn_commit (do_ertn),
        .era         (era),
        .eentry      (eentry)
    );

    assign rf_we        = ws_valid && !ws_ex && !ws_csr_op[OP_ERTN] && ws_gr_we;
    assign rf_waddr     = ws_dest;
    assign rf_wdata     = do_csr ? csr_rdata : ws_result;
    assign flush        = do_ex || do_ertn;
    assign flush_target = do_ex ? eentry : era;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
